// File: rtl/instr_mem_loader_if.sv
// ---------------------------------------------------------------------------
// instr_mem_loader_if
// Bundles the loader's UART-side inputs and BRAM/status outputs.
//   i_start     : one-cycle pulse, begin a load at word address 0
//   i_rx_data   : received byte, valid while i_rx_done is high
//   i_rx_done   : one-cycle receive strobe
//   o_w_enable  : BRAM write strobe, one cycle per word
//   o_address   : BRAM word address of the current strobe
//   o_data      : BRAM write data
//   o_busy      : loading in progress (fetch PC_write = ~o_busy)
//   o_done      : load finished, held until next i_start or reset
//   o_overflow  : memory filled without a halt word
//   o_error     : checksum mismatch (0 unless LOADER_CHECKSUM_EN)
// Modports: master drives the inputs (UART side / bench), slave is the loader.
// ---------------------------------------------------------------------------
interface instr_mem_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              i_start;
  logic [7:0]        i_rx_data;
  logic              i_rx_done;
  logic              o_w_enable;
  logic [ADDR_W-1:0] o_address;
  logic [DATA_W-1:0] o_data;
  logic              o_busy;
  logic              o_done;
  logic              o_overflow;
  logic              o_error;

  modport master (
    output i_start, i_rx_data, i_rx_done,
    input  o_w_enable, o_address, o_data, o_busy, o_done, o_overflow, o_error
  );

  modport slave (
    input  i_start, i_rx_data, i_rx_done,
    output o_w_enable, o_address, o_data, o_busy, o_done, o_overflow, o_error
  );
endinterface

// File: rtl/instr_mem_loader.sv
// ---------------------------------------------------------------------------
// instr_mem_loader
// Packs a UART byte stream into 32-bit big-endian instruction words and
// writes them to the instruction BRAM at incrementing word addresses.
// Loading ends after a HALT_WORD is written or after the last address
// (2^ADDR_W-1) is written, the latter flagging o_overflow.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined   : an 8-bit XOR of every loaded byte is compared against one
//               trailing checksum byte (CHECK state); o_error on mismatch.
//   undefined : no CHECK state, o_error tied low.
//
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-low reset
//   bus : instr_mem_loader_if.slave (see interface file for signal list)
// ---------------------------------------------------------------------------
module instr_mem_loader #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 8,
  parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_mem_loader_if.slave     bus
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_DONE  = 2'd3
  } state_t;
`endif

  state_t state_q, state_d;

  // Holds only the first three bytes of a word; the fourth comes straight
  // from i_rx_data when the word completes.
  logic [DATA_W-9:0] asm_q;
  logic [1:0]        byte_cnt_q;
  logic [ADDR_W-1:0] word_addr_q;

  logic              w_enable_q;
  logic [ADDR_W-1:0] address_q;
  logic [DATA_W-1:0] data_q;
  logic              overflow_q;

  logic              launch;
  logic              byte_ok;
  logic              word_done;
  logic [DATA_W-1:0] word_next;
  logic              term;
  logic              ovf_set;

  assign launch    = ((state_q == S_IDLE) || (state_q == S_DONE)) && bus.i_start;
  assign byte_ok   = (state_q == S_RECV) && bus.i_rx_done;
  assign word_next = {asm_q, bus.i_rx_data};
  assign word_done = byte_ok && (byte_cnt_q == 2'd3);

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q;
  logic       error_q;
  logic       csum_byte;
  logic       addr_last;

  // Termination is decided as the word completes, so the CHECK state is
  // already listening when the checksum byte follows the final word.
  assign addr_last = (word_addr_q == {ADDR_W{1'b1}});
  assign term      = word_done && ((word_next == HALT_WORD) || addr_last);
  assign ovf_set   = term && (word_next != HALT_WORD);
  assign csum_byte = (state_q == S_CHECK) && bus.i_rx_done;
`else
  logic halt_strobe;
  logic last_strobe;

  // Termination is decided in the strobe cycle itself so DONE is reached on
  // the edge right after the final write.
  assign halt_strobe = w_enable_q && (data_q == HALT_WORD);
  assign last_strobe = w_enable_q && (address_q == {ADDR_W{1'b1}});
  assign term        = (state_q == S_RECV) && (halt_strobe || last_strobe);
  assign ovf_set     = term && !halt_strobe;
`endif

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: defaulting state_d before the case keeps every path assigned,
    // so no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE: if (launch) state_d = S_RECV;
`ifdef LOADER_CHECKSUM_EN
      S_RECV:  if (term)      state_d = S_CHECK;
      S_CHECK: if (csum_byte) state_d = S_DONE;
`else
      S_RECV: if (term) state_d = S_DONE;
`endif
      S_DONE: if (launch) state_d = S_RECV;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: byte assembly, word address, write strobe and flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: everything is reset here, including the assembly register, so
      // a reset mid-word leaves no stale bytes in any observable state.
      asm_q       <= '0;
      byte_cnt_q  <= '0;
      word_addr_q <= '0;
      w_enable_q  <= 1'b0;
      address_q   <= '0;
      data_q      <= '0;
      overflow_q  <= 1'b0;
    end else begin
      w_enable_q <= 1'b0;

      if (launch) begin
        byte_cnt_q  <= '0;
        word_addr_q <= '0;
        overflow_q  <= 1'b0;
      end

      if (byte_ok) begin
        asm_q      <= word_next[DATA_W-9:0];
        byte_cnt_q <= byte_cnt_q + 2'd1;
        if (byte_cnt_q == 2'd3) begin
          data_q      <= word_next;
          address_q   <= word_addr_q;
          w_enable_q  <= 1'b1;
          word_addr_q <= word_addr_q + 1'b1;
        end
      end

      if (ovf_set) overflow_q <= 1'b1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      csum_q  <= '0;
      error_q <= 1'b0;
    end else begin
      if (launch) begin
        csum_q  <= '0;
        error_q <= 1'b0;
      end
      if (byte_ok)   csum_q  <= csum_q ^ bus.i_rx_data;
      if (csum_byte) error_q <= (bus.i_rx_data != csum_q);
    end
  end

  assign bus.o_error = error_q;
  assign bus.o_busy  = (state_q == S_RECV) || (state_q == S_CHECK);
`else
  assign bus.o_error = 1'b0;
  assign bus.o_busy  = (state_q == S_RECV);
`endif

  assign bus.o_w_enable = w_enable_q;
  assign bus.o_address  = address_q;
  assign bus.o_data     = data_q;
  assign bus.o_done     = (state_q == S_DONE);
  assign bus.o_overflow = overflow_q;

endmodule
